// File: rtl/repeat_pattern_scheduler.sv
// Repeat-pattern scheduler: expands one row of a latched 2D bit pattern into
// a 32-bit 1D row pattern per sensor row, handing each row to the MG block
// with a one-cycle load_pattern strobe and waiting for rp_valid before moving on.
// Only the "repeated" mask type is scheduled; other types leave the block untouched.

module repeat_pattern_scheduler #(
    parameter int max_image_sensor_w = 50,
    parameter int max_image_sensor_h = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [10:0] image_sensor_w,
    input  logic [10:0] image_sensor_h,
    input  logic [4:0]  pattern_w,
    input  logic [4:0]  pattern_h,
    input  logic [0:63] full_pattern,
    input  logic        start_pattern_2D,
    input  logic [1:0]  mask_type,
    input  logic        rp_valid,
    output logic        load_pattern,
    output logic [0:31] pattern
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [1:0] MASK_REPEATED = 2'b00;

    state_t      state;

    // Values captured on an accepted start; the schedule only ever reads these.
    logic [0:63] fp_q;
    logic [4:0]  pw_q;
    logic [4:0]  ph_q;
    logic [10:0] sw_q;
    logic [10:0] sh_q;

    // row_count is the absolute sensor row r; row_mod is r mod pattern_h and
    // row_base is row_mod*pattern_w, both advanced incrementally so that no
    // runtime division or wide multiply is needed to locate the pattern row.
    logic [10:0] row_count;
    logic [4:0]  row_mod;
    logic [5:0]  row_base;

    logic [9:0]  start_area;
    logic        start_ok;
    logic        last_row;
    logic        row_wrap;
    logic [4:0]  next_mod;
    logic [5:0]  next_base;
    logic [0:31] first_row;
    logic [0:31] next_row;
    logic        unused_info;

    // Replicates the pattern row that starts at bit 'base' across all 32
    // output bits, restarting the column every 'width' bits; a width that
    // does not divide 32 simply leaves a truncated copy at the end.
    function automatic logic [0:31] expand_row(
        input logic [0:63] src,
        input logic [5:0]  base,
        input logic [4:0]  width
    );
        logic [0:31] row;
        logic [4:0]  col;
        logic [5:0]  idx;
        row = '0;
        col = 5'd0;
        for (int i = 0; i < 32; i++) begin
            idx    = base + {1'b0, col};
            row[i] = src[idx];
            col    = (col == width - 5'd1) ? 5'd0 : col + 5'd1;
        end
        return row;
    endfunction

    // A start is only honoured for the repeated mask and dimensions whose
    // pattern fits inside the 64-bit full_pattern with at least one row to send.
    assign start_area = {5'd0, pattern_w} * {5'd0, pattern_h};
    assign start_ok   = start_pattern_2D
                     && (mask_type == MASK_REPEATED)
                     && (pattern_w != 5'd0)
                     && (pattern_h != 5'd0)
                     && (start_area <= 10'd64)
                     && (image_sensor_h != 11'd0);

    assign last_row  = (row_count == sh_q - 11'd1);
    assign row_wrap  = (row_mod == ph_q - 5'd1);
    assign next_mod  = row_wrap ? 5'd0 : row_mod + 5'd1;
    assign next_base = row_wrap ? 6'd0 : row_base + {1'b0, pw_q};

    // Row 0 comes straight from the inputs being latched; later rows come
    // from the latched copy at the next pattern-row offset.
    assign first_row = expand_row(full_pattern, 6'd0, pattern_w);
    assign next_row  = expand_row(fp_q, next_base, pw_q);

    // Sensor width and the sizing parameters are carried for the other mask
    // types and do not influence repeated-pattern scheduling.
    assign unused_info = (^sw_q) ^ (max_image_sensor_w > 0) ^ (max_image_sensor_h > 0);

    // Scheduler FSM with registered strobe and pattern outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            fp_q         <= '0;
            pw_q         <= '0;
            ph_q         <= '0;
            sw_q         <= '0;
            sh_q         <= '0;
            row_count    <= '0;
            row_mod      <= '0;
            row_base     <= '0;
            load_pattern <= 1'b0;
            pattern      <= '0;
        end else if (clk_en) begin
            if (start_ok) begin
                fp_q         <= full_pattern;
                pw_q         <= pattern_w;
                ph_q         <= pattern_h;
                sw_q         <= image_sensor_w;
                sh_q         <= image_sensor_h;
                row_count    <= '0;
                row_mod      <= '0;
                row_base     <= '0;
                pattern      <= first_row;
                load_pattern <= 1'b1;
                state        <= SEND;
            end else begin
                case (state)
                    IDLE: begin
                        load_pattern <= 1'b0;
                    end
                    SEND: begin
                        load_pattern <= 1'b0;
                        state        <= WAIT;
                    end
                    WAIT: begin
                        load_pattern <= 1'b0;
                        if (rp_valid) begin
                            row_count <= row_count + 11'd1;
                            if (last_row) begin
                                state <= IDLE;
                            end else begin
                                row_mod      <= next_mod;
                                row_base     <= next_base;
                                pattern      <= next_row;
                                load_pattern <= 1'b1;
                                state        <= SEND;
                            end
                        end
                    end
                    default: begin
                        load_pattern <= 1'b0;
                        state        <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_repeat_pattern_scheduler.sv
// Testbench for repeat_pattern_scheduler: directed scenarios plus a random
// run, all compared against a row-arithmetic reference model.

module tb_repeat_pattern_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [10:0] image_sensor_w;
    logic [10:0] image_sensor_h;
    logic [4:0]  pattern_w;
    logic [4:0]  pattern_h;
    logic [0:63] full_pattern;
    logic        start_pattern_2D;
    logic [1:0]  mask_type;
    logic        rp_valid;
    logic        load_pattern;
    logic [0:31] pattern;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the MG block should currently see.
    logic [0:63] m_fp;
    int          m_pw, m_ph, m_sh, m_r;
    bit          m_busy;
    logic        m_load;
    logic [0:31] m_pat;

    localparam logic [0:63] SPEC_FP = 64'hF0ABC9820EAA17CD;

    repeat_pattern_scheduler #(
        .max_image_sensor_w(50),
        .max_image_sensor_h(50)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .clk_en           (clk_en),
        .image_sensor_w   (image_sensor_w),
        .image_sensor_h   (image_sensor_h),
        .pattern_w        (pattern_w),
        .pattern_h        (pattern_h),
        .full_pattern     (full_pattern),
        .start_pattern_2D (start_pattern_2D),
        .mask_type        (mask_type),
        .rp_valid         (rp_valid),
        .load_pattern     (load_pattern),
        .pattern          (pattern)
    );

    always #5 clk = ~clk;

    function automatic logic [0:31] model_row(input logic [0:63] fp, input int pw, input int ph, input int r);
        logic [0:31] res;
        for (int i = 0; i < 32; i++) res[i] = fp[(r % ph) * pw + (i % pw)];
        return res;
    endfunction

    task automatic model_reset();
        m_fp = '0; m_pw = 0; m_ph = 0; m_sh = 0; m_r = 0;
        m_busy = 1'b0; m_load = 1'b0; m_pat = '0;
    endtask

    task automatic model_edge();
        int pw, ph, sh;
        bit ok;
        pw = int'(pattern_w);
        ph = int'(pattern_h);
        sh = int'(image_sensor_h);
        if (rst) begin
            model_reset();
        end else if (clk_en) begin
            ok = start_pattern_2D && (mask_type == 2'b00) && (pw >= 1) && (ph >= 1) && (pw * ph <= 64) && (sh >= 1);
            if (ok) begin
                m_fp = full_pattern; m_pw = pw; m_ph = ph; m_sh = sh; m_r = 0;
                m_busy = 1'b1; m_load = 1'b1;
                m_pat = model_row(m_fp, m_pw, m_ph, 0);
            end else if (m_load) begin
                m_load = 1'b0;
            end else if (m_busy && rp_valid) begin
                m_r++;
                if (m_r == m_sh) begin
                    m_busy = 1'b0;
                end else begin
                    m_pat  = model_row(m_fp, m_pw, m_ph, m_r);
                    m_load = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic launch(input logic [0:63] fp, input int pw, input int ph, input int sh);
        full_pattern     = fp;
        pattern_w        = 5'(pw);
        pattern_h        = 5'(ph);
        image_sensor_h   = 11'(sh);
        image_sensor_w   = 11'd50;
        mask_type        = 2'b00;
        start_pattern_2D = 1'b1;
        tick();
        start_pattern_2D = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (load_pattern !== 1'b0 || pattern !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL reset_state: load=%0b pattern=%h, expected load=0 pattern=00000000", load_pattern, pattern);
        end
        rst = 1'b0;
        rp_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (load_pattern !== 1'b0 || pattern !== 32'h0) begin
                n_errors++;
                $display("[TB] FAIL idle_after_reset%0d: load=%0b pattern=%h, expected load=0 pattern=00000000", c, load_pattern, pattern);
            end
        end
        rp_valid = 1'b0;
    endtask

    task automatic test_basic_rows();
        logic [31:0] exp_rows [5];
        exp_rows = '{32'hFFFFFFFF, 32'h00000000, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hFFFFFFFF};
        launch(SPEC_FP, 4, 4, 50);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (load_pattern !== 1'b1 || pattern !== exp_rows[k] || pattern !== m_pat) begin
                n_errors++;
                $display("[TB] FAIL basic_row%0d: load=%0b pattern=%h, expected load=1 pattern=%h", k, load_pattern, pattern, exp_rows[k]);
            end
            tick();
            tick();
            n_checks++;
            if (load_pattern !== 1'b0 || pattern !== exp_rows[k]) begin
                n_errors++;
                $display("[TB] FAIL basic_hold%0d: load=%0b pattern=%h, expected load=0 pattern=%h", k, load_pattern, pattern, exp_rows[k]);
            end
            rp_valid = 1'b1;
            tick();
            rp_valid = 1'b0;
        end
    endtask

    task automatic test_hold_and_end();
        int strobes;
        int cycles;
        launch(SPEC_FP, 8, 8, 50);
        strobes = 0;
        for (cycles = 0; cycles < 2000 && (m_busy || m_load); cycles++) begin
            n_checks++;
            if (load_pattern !== m_load || pattern !== m_pat) begin
                n_errors++;
                $display("[TB] FAIL hold_row%0d: load=%0b pattern=%h, expected load=%0b pattern=%h", m_r, load_pattern, pattern, m_load, m_pat);
            end
            if (load_pattern === 1'b1) strobes++;
            rp_valid = 1'($urandom_range(0, 1));
            tick();
        end
        rp_valid = 1'b0;
        n_checks++;
        if (cycles >= 2000) begin
            n_errors++;
            $display("[TB] FAIL hold_timeout: cycles=%0d, expected schedule end before 2000", cycles);
        end
        n_checks++;
        if (strobes != 50) begin
            n_errors++;
            $display("[TB] FAIL hold_strobe_count: got %0d, expected 50", strobes);
        end
        rp_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (load_pattern !== 1'b0 || pattern !== 32'hABABABAB) begin
                n_errors++;
                $display("[TB] FAIL end_hold%0d: load=%0b pattern=%h, expected load=0 pattern=abababab", c, load_pattern, pattern);
            end
        end
        rp_valid = 1'b0;
    endtask

    task automatic test_rejected_start();
        logic [1:0] masks [5];
        int pws [5];
        int phs [5];
        int shs [5];
        masks = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
        pws   = '{4, 0, 9, 4, 4};
        phs   = '{4, 4, 9, 4, 4};
        shs   = '{50, 50, 50, 0, 50};
        for (int k = 0; k < 5; k++) begin
            full_pattern     = {$urandom, $urandom};
            mask_type        = masks[k];
            pattern_w        = 5'(pws[k]);
            pattern_h        = 5'(phs[k]);
            image_sensor_h   = 11'(shs[k]);
            start_pattern_2D = 1'b1;
            tick();
            start_pattern_2D = 1'b0;
            mask_type        = 2'b00;
            for (int c = 0; c < 2; c++) begin
                n_checks++;
                if (load_pattern !== 1'b0 || pattern !== 32'hABABABAB) begin
                    n_errors++;
                    $display("[TB] FAIL reject%0d_c%0d: load=%0b pattern=%h, expected load=0 pattern=abababab", k, c, load_pattern, pattern);
                end
                tick();
            end
        end
        launch(SPEC_FP, 4, 4, 10);
        tick();
        full_pattern     = 64'h0123456789ABCDEF;
        mask_type        = 2'b01;
        start_pattern_2D = 1'b1;
        tick();
        start_pattern_2D = 1'b0;
        mask_type        = 2'b00;
        n_checks++;
        if (load_pattern !== 1'b0 || pattern !== 32'hFFFFFFFF) begin
            n_errors++;
            $display("[TB] FAIL reject_mid: load=%0b pattern=%h, expected load=0 pattern=ffffffff", load_pattern, pattern);
        end
        rp_valid = 1'b1;
        tick();
        rp_valid = 1'b0;
        n_checks++;
        if (load_pattern !== 1'b1 || pattern !== 32'h00000000 || pattern !== m_pat) begin
            n_errors++;
            $display("[TB] FAIL reject_mid_next: load=%0b pattern=%h, expected load=1 pattern=00000000", load_pattern, pattern);
        end
    endtask

    task automatic test_clk_en();
        launch({$urandom, $urandom}, 5, 3, 8);
        clk_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (load_pattern !== 1'b1 || pattern !== m_pat) begin
                n_errors++;
                $display("[TB] FAIL en_hold_send%0d: load=%0b pattern=%h, expected load=1 pattern=%h", c, load_pattern, pattern, m_pat);
            end
        end
        clk_en = 1'b1;
        tick();
        clk_en   = 1'b0;
        rp_valid = 1'b1;
        full_pattern     = 64'hFFFF0000FFFF0000;
        start_pattern_2D = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (load_pattern !== 1'b0 || pattern !== m_pat || m_r != 0) begin
                n_errors++;
                $display("[TB] FAIL en_hold_wait%0d: load=%0b pattern=%h, expected load=0 pattern=%h", c, load_pattern, pattern, m_pat);
            end
        end
        start_pattern_2D = 1'b0;
        clk_en = 1'b1;
        tick();
        rp_valid = 1'b0;
        n_checks++;
        if (load_pattern !== 1'b1 || pattern !== m_pat || m_r != 1) begin
            n_errors++;
            $display("[TB] FAIL en_resume: load=%0b pattern=%h, expected load=1 pattern=%h", load_pattern, pattern, m_pat);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (load_pattern !== 1'b0 || pattern !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL reset_async: load=%0b pattern=%h, expected load=0 pattern=00000000", load_pattern, pattern);
        end
        tick();
        rst      = 1'b0;
        rp_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (load_pattern !== 1'b0 || pattern !== 32'h0) begin
                n_errors++;
                $display("[TB] FAIL reset_mid_idle%0d: load=%0b pattern=%h, expected load=0 pattern=00000000", c, load_pattern, pattern);
            end
        end
        rp_valid = 1'b0;
    endtask

    task automatic test_priority();
        launch(SPEC_FP, 4, 4, 20);
        tick();
        rp_valid = 1'b1;
        tick();
        rp_valid = 1'b0;
        tick();
        rp_valid         = 1'b1;
        start_pattern_2D = 1'b1;
        tick();
        rp_valid         = 1'b0;
        start_pattern_2D = 1'b0;
        n_checks++;
        if (load_pattern !== 1'b1 || pattern !== 32'hFFFFFFFF || pattern !== m_pat) begin
            n_errors++;
            $display("[TB] FAIL priority_restart: load=%0b pattern=%h, expected load=1 pattern=ffffffff", load_pattern, pattern);
        end
        tick();
        rp_valid = 1'b1;
        tick();
        rp_valid = 1'b0;
        n_checks++;
        if (load_pattern !== 1'b1 || pattern !== 32'h00000000) begin
            n_errors++;
            $display("[TB] FAIL priority_row1: load=%0b pattern=%h, expected load=1 pattern=00000000", load_pattern, pattern);
        end
    endtask

    task automatic test_random();
        int lim;
        int pw;
        for (int c = 0; c < 1500; c++) begin
            clk_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 14) == 0) begin
                start_pattern_2D = 1'b1;
                mask_type = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                pw  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31));
                lim = (pw == 0) ? 31 : 64 / pw;
                if (lim > 30) lim = 30;
                pattern_w      = 5'(pw);
                pattern_h      = 5'($urandom_range(0, lim + 1));
                image_sensor_h = 11'($urandom_range(0, 6));
                image_sensor_w = 11'($urandom_range(0, 2047));
                full_pattern   = {$urandom, $urandom};
            end else begin
                start_pattern_2D = 1'b0;
            end
            rp_valid = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (load_pattern !== m_load || pattern !== m_pat) begin
                n_errors++;
                $display("[TB] FAIL random_cyc%0d: load=%0b pattern=%h, expected load=%0b pattern=%h", c, load_pattern, pattern, m_load, m_pat);
            end
        end
        start_pattern_2D = 1'b0;
        rp_valid         = 1'b0;
        clk_en           = 1'b1;
    endtask

    initial begin
        rst              = 1'b1;
        clk_en           = 1'b1;
        start_pattern_2D = 1'b0;
        rp_valid         = 1'b0;
        mask_type        = 2'b00;
        pattern_w        = 5'd4;
        pattern_h        = 5'd4;
        image_sensor_w   = 11'd50;
        image_sensor_h   = 11'd50;
        full_pattern     = '0;
        model_reset();

        test_reset();
        test_basic_rows();
        test_hold_and_end();
        test_rejected_start();
        test_clk_en();
        test_reset_mid();
        test_priority();
        test_random();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
